// File: rtl/reg_file_alu_unit.sv
// Purpose: 16 x 8-bit register file feeding a 2-operand 8-bit ALU, with write-back and a registered result copy.
// Latency: ALUResult and Zero are combinational; register write-back and cpu_out update one CLK edge later.
// Backpressure: none; every cycle with write_enable=1 commits, so the caller owns sequencing.
//
// Ports:
//   CLK, RST        - single clock; synchronous active-high reset (clears R0-R15 and cpu_out)
//   RA1, RA2        - asynchronous read addresses for operand A and register-path operand B
//   WA              - write-back address
//   immediate       - immediate operand B
//   ALUControl      - 00 add, 01 sub, 10 and, 11 or
//   write_enable    - commit ALUResult to R[WA] and cpu_out at the rising edge
//   ALUSrc          - operand B select: 1 immediate, 0 R[RA2]
//   ALUResult, Zero - combinational ALU result and its zero flag
//   cpu_out         - last written-back value
//
// Build option: define REG_FILE_ALU_R0_ZERO_EN to make R0 read as zero and discard writes to it.

module reg_file_alu_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] RA1,
    input  logic [3:0] RA2,
    input  logic [3:0] WA,
    input  logic [7:0] immediate,
    input  logic [1:0] ALUControl,
    input  logic       write_enable,
    input  logic       ALUSrc,
    output logic [7:0] ALUResult,
    output logic [7:0] cpu_out,
    output logic       Zero
);

`ifdef REG_FILE_ALU_R0_ZERO_EN
    localparam logic R0_HARDWIRED = 1'b1;
`else
    localparam logic R0_HARDWIRED = 1'b0;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [7:0] regs [16];
    logic [7:0] rd1_dat;
    logic [7:0] rd2_dat;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic       wr_allowed;

    // Read ports see the array as it stood before the edge, so a same-cycle
    // write is not bypassed: new data appears only after the clock edge.
    always_comb begin
        rd1_dat = regs[RA1];
        rd2_dat = regs[RA2];
        if (R0_HARDWIRED && (RA1 == 4'd0)) begin
            rd1_dat = 8'h00;
        end
        if (R0_HARDWIRED && (RA2 == 4'd0)) begin
            rd2_dat = 8'h00;
        end
    end

    always_comb begin
        src_a = rd1_dat;
        src_b = ALUSrc ? immediate : rd2_dat;
    end

    // Add/sub wrap modulo 256; carry and borrow are intentionally dropped.
    always_comb begin
        ALUResult = 8'h00;
        case (ALUControl)
            OP_ADD: ALUResult = src_a + src_b;
            OP_SUB: ALUResult = src_a - src_b;
            OP_AND: ALUResult = src_a & src_b;
            OP_OR:  ALUResult = src_a | src_b;
            default: ALUResult = 8'h00;
        endcase
    end

    assign Zero = (ALUResult == 8'h00);

    // With R0 hardwired the register write is suppressed, but cpu_out still
    // captures the result so software can observe it.
    assign wr_allowed = !(R0_HARDWIRED && (WA == 4'd0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
            cpu_out <= 8'h00;
        end else if (write_enable) begin
            if (wr_allowed) begin
                regs[WA] <= ALUResult;
            end
            cpu_out <= ALUResult;
        end
    end

endmodule

// File: tb/tb_reg_file_alu_unit.sv
// Purpose: scoreboard bench for reg_file_alu_unit using directed vectors with hand-computed results.
// Latency: expectations are queued just after a rising edge and checked at the following falling edge.
// Backpressure: none; the monitor drains one expectation per cycle.

module tb_reg_file_alu_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] RA1;
    logic [3:0] RA2;
    logic [3:0] WA;
    logic [7:0] immediate;
    logic [1:0] ALUControl;
    logic       write_enable;
    logic       ALUSrc;
    logic [7:0] ALUResult;
    logic [7:0] cpu_out;
    logic       Zero;

    typedef struct {
        string      name;
        logic [7:0] alu;
        logic       z;
        logic [7:0] cpu;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    reg_file_alu_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .RA1         (RA1),
        .RA2         (RA2),
        .WA          (WA),
        .immediate   (immediate),
        .ALUControl  (ALUControl),
        .write_enable(write_enable),
        .ALUSrc      (ALUSrc),
        .ALUResult   (ALUResult),
        .cpu_out     (cpu_out),
        .Zero        (Zero)
    );

    always #5 CLK = ~CLK;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares outputs at the falling edge against queued expectations.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check8({e.name, ".alu"}, ALUResult, e.alu);
            check8({e.name, ".zero"}, {7'd0, Zero}, {7'd0, e.z});
            check8({e.name, ".cpu_out"}, cpu_out, e.cpu);
        end
    end

    // One cycle of stimulus: apply inputs after the rising edge, queue the
    // expected outputs for that cycle. Writes land on the next rising edge.
    task automatic step(input string name, input logic rst,
                        input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                        input logic [7:0] imm, input logic [1:0] ctl,
                        input logic we, input logic src,
                        input logic [7:0] e_alu, input logic e_z, input logic [7:0] e_cpu);
        exp_t e;
        @(posedge CLK);
        #1;
        RST          = rst;
        RA1          = ra1;
        RA2          = ra2;
        WA           = wa;
        immediate    = imm;
        ALUControl   = ctl;
        write_enable = we;
        ALUSrc       = src;
        e.name = name;
        e.alu  = e_alu;
        e.z    = e_z;
        e.cpu  = e_cpu;
        exp_q.push_back(e);
    endtask

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

`ifdef REG_FILE_ALU_R0_ZERO_EN
    localparam logic [7:0] R0_AFTER_WR = 8'h00;
`else
    localparam logic [7:0] R0_AFTER_WR = 8'h07;
`endif

    initial begin
        RST = 1'b1; RA1 = '0; RA2 = '0; WA = '0; immediate = '0;
        ALUControl = '0; write_enable = 1'b0; ALUSrc = 1'b0;
        repeat (2) @(posedge CLK);

        //     name           rst  ra1    ra2    wa     imm    ctl  we    src    alu    z     cpu
        step("rst_state",    1'b0, 4'd0,  4'd0,  4'd0,  8'h00, ADD, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        step("imm16",        1'b0, 4'd1,  4'd0,  4'd0,  8'd16, ADD, 1'b0, 1'b1, 8'd16, 1'b0, 8'h00);
        step("wr_r12",       1'b0, 4'd8,  4'd0,  4'd12, 8'd5,  ADD, 1'b1, 1'b1, 8'd5,  1'b0, 8'h00);
        step("rd_r12",       1'b0, 4'd12, 4'd0,  4'd0,  8'd0,  ADD, 1'b0, 1'b1, 8'd5,  1'b0, 8'd5);
        step("sub_self",     1'b0, 4'd12, 4'd12, 4'd0,  8'd0,  SUB, 1'b0, 1'b0, 8'd0,  1'b1, 8'd5);
        step("or_self",      1'b0, 4'd12, 4'd12, 4'd0,  8'd0,  OR,  1'b0, 1'b0, 8'd5,  1'b0, 8'd5);
        step("wrap_r15",     1'b0, 4'd12, 4'd0,  4'd15, 8'd255,ADD, 1'b1, 1'b1, 8'd4,  1'b0, 8'd5);
        step("rd_r15",       1'b0, 4'd15, 4'd0,  4'd0,  8'd0,  ADD, 1'b0, 1'b1, 8'd4,  1'b0, 8'd4);
        step("and_f0",       1'b0, 4'd12, 4'd0,  4'd0,  8'hF0, AND, 1'b0, 1'b1, 8'h00, 1'b1, 8'd4);
        step("sub_borrow",   1'b0, 4'd15, 4'd12, 4'd0,  8'd0,  SUB, 1'b0, 1'b0, 8'hFF, 1'b0, 8'd4);
        step("and_reg",      1'b0, 4'd15, 4'd12, 4'd0,  8'd0,  AND, 1'b0, 1'b0, 8'd4,  1'b0, 8'd4);
        step("same_cyc_old", 1'b0, 4'd12, 4'd0,  4'd12, 8'd3,  ADD, 1'b1, 1'b1, 8'd8,  1'b0, 8'd4);
        step("same_cyc_new", 1'b0, 4'd12, 4'd0,  4'd0,  8'd0,  ADD, 1'b0, 1'b1, 8'd8,  1'b0, 8'd8);
        step("hold_drive",   1'b0, 4'd12, 4'd0,  4'd12, 8'd1,  ADD, 1'b0, 1'b1, 8'd9,  1'b0, 8'd8);
        step("hold_check",   1'b0, 4'd12, 4'd0,  4'd0,  8'd0,  ADD, 1'b0, 1'b1, 8'd8,  1'b0, 8'd8);
        step("wr_r0",        1'b0, 4'd0,  4'd0,  4'd0,  8'd7,  ADD, 1'b1, 1'b1, 8'd7,  1'b0, 8'd8);
        step("rd_r0",        1'b0, 4'd0,  4'd0,  4'd0,  8'd0,  OR,  1'b0, 1'b0, R0_AFTER_WR, (R0_AFTER_WR == 8'h00), 8'd7);
        step("rst_with_we",  1'b1, 4'd12, 4'd0,  4'd3,  8'd1,  ADD, 1'b1, 1'b1, 8'd9,  1'b0, 8'd7);
        step("post_rst_r3",  1'b0, 4'd3,  4'd12, 4'd0,  8'd0,  OR,  1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        step("post_rst_r15", 1'b0, 4'd15, 4'd8,  4'd0,  8'd0,  ADD, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        step("post_rst_imm", 1'b0, 4'd12, 4'd0,  4'd0,  8'h2A, OR,  1'b0, 1'b1, 8'h2A, 1'b0, 8'h00);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge CLK);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_alu_unit.md
REG_FILE_ALU_UNIT -- requirements
Module: reg_file_alu

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port RA1, input, 4 bits: read address for operand A.
REQ-004 SHALL have port RA2, input, 4 bits: read address for operand B (register path).
REQ-005 SHALL have port WA, input, 4 bits: write address for write-back.
REQ-006 SHALL have port immediate, input, 8 bits: immediate operand B.
REQ-007 SHALL have port ALUControl, input, 2 bits: ALU operation select.
REQ-008 SHALL have port write_enable, input, 1 bit: write ALUResult to register WA at the clock edge.
REQ-009 SHALL have port ALUSrc, input, 1 bit: operand B select (1 = immediate, 0 = register RA2).
REQ-010 SHALL have port ALUResult, output, 8 bits: combinational ALU result.
REQ-011 SHALL have port cpu_out, output, 8 bits: registered copy of the last written-back value.
REQ-012 SHALL have port Zero, output, 1 bit: high when ALUResult == 0.

Function
REQ-013 SHALL contain 16 registers of 8 bits each (R0-R15), with two asynchronous read ports and one synchronous write port.
REQ-014 SHALL drive SrcA = R[RA1] and SrcB = ALUSrc ? immediate : R[RA2], both combinational.
REQ-015 SHALL select the ALU operation from ALUControl: 00 = SrcA+SrcB, 01 = SrcA-SrcB, 10 = SrcA AND SrcB, 11 = SrcA OR SrcB.
REQ-016 SHALL compute add and sub modulo 256: carry and borrow discarded, no flags other than Zero.
REQ-017 SHALL drive Zero = (ALUResult == 8'h00), combinational.
REQ-018 SHALL, on a rising CLK edge with write_enable=1 and RST=0, write ALUResult into R[WA] and load cpu_out with ALUResult.
REQ-019 SHALL hold all registers and cpu_out when write_enable=0.
REQ-020 SHALL return the pre-edge (old) value when a register is read in the same cycle it is written; new data becomes visible after the edge.
REQ-021 SHALL use only the 4-bit address value; wider testbench values are truncated (e.g. 16 addresses R0).

Reset
REQ-022 SHALL, on a rising CLK edge with RST=1, clear R0-R15 and cpu_out to 8'h00.
REQ-023 SHALL give RST priority over write_enable: no write occurs in a reset cycle.
REQ-024 SHALL keep ALUResult and Zero combinational during reset; after reset with ALUSrc=0 and ALUControl=00, ALUResult=0 and Zero=1.

Configuration
REQ-025 SHALL support the macro REG_FILE_ALU_R0_ZERO_EN.
REQ-026 SHALL, when REG_FILE_ALU_R0_ZERO_EN is defined, read R0 as 8'h00 always and ignore writes to R0; cpu_out still loads ALUResult.
REQ-027 SHALL, when REG_FILE_ALU_R0_ZERO_EN is not defined, treat R0 as an ordinary writable register.

Verification
REQ-028 SHALL be verified for this case: after reset, RA1=1, ALUSrc=1, immediate=16, ALUControl=00 -> ALUResult=16, Zero=0, cpu_out=0.
REQ-029 SHALL be verified for this case: WA=12, RA1=8, immediate=5, ALUSrc=1, add, write_enable=1, one edge -> R12=5, cpu_out=5; next cycle RA1=12 reads 5.
REQ-030 SHALL be verified for this case: RA1=12, RA2=12, ALUSrc=0, ALUControl=01 -> ALUResult=0, Zero=1; with ALUControl=11 -> ALUResult=5, Zero=0.
REQ-031 SHALL be verified for this case: R12=5, immediate=255, add, WA=15, write -> R15=4 (wrap), cpu_out=4; immediate=8'hF0 with AND -> 0, Zero=1.
REQ-032 SHALL be verified for this case: WA=0, RA1=0, immediate=7, add, write -> RA1=0 later reads 0 with the macro, 7 without.
REQ-033 SHALL be verified for this case: RST=1 together with write_enable=1, WA=3 -> after the edge R3=0, all registers and cpu_out=0.
